// File: rtl/neuron_cfg_pkg.sv
// Shared definitions for the neuron configuration path: packet layout, error codes,
// loader FSM states and parameter field widths used by both loader and neuron.
package neuron_cfg_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         PKT_LEN        = 7;

  localparam int W_WEIGHT = 3;
  localparam int W_LEAK   = 8;
  localparam int W_THR    = 8;
  localparam int W_CYC    = 4;

  localparam logic [2:0] IDX_HEADER = 3'd0;
  localparam logic [2:0] IDX_WEIGHT = 3'd1;
  localparam logic [2:0] IDX_LEAK1  = 3'd2;
  localparam logic [2:0] IDX_LEAK2  = 3'd3;
  localparam logic [2:0] IDX_THR    = 3'd4;
  localparam logic [2:0] IDX_CYC    = 3'd5;
  localparam logic [2:0] IDX_CKSUM  = 3'd6;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CKSUM   = 2'b01,
    ERR_RANGE   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/neuron_param_loader.sv
// Framed byte-stream loader for the ALIF dual-leak neuron parameters; a packet is
// checked for checksum and threshold range, then all fields commit on one edge.
//
// state | meaning
// IDLE  | hunting for HEADER, other bytes dropped
// RECV  | collecting B1..B6 into shadow, timeout armed
// CHECK | one cycle verdict: commit or flag error, rx_ready low
module neuron_param_loader
  import neuron_cfg_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         TIMEOUT_CYC = 255,
  parameter int         CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  input  logic                err_clear,
  output logic [W_WEIGHT-1:0] weight_a,
  output logic [W_LEAK-1:0]   leak_rate_1,
  output logic [W_LEAK-1:0]   leak_rate_2,
  output logic [W_THR-1:0]    threshold_min,
  output logic [W_CYC-1:0]    leak_cycles_1,
  output logic [W_CYC-1:0]    leak_cycles_2,
  output logic                params_ready,
  output logic                load_busy,
  output logic                load_err,
  output logic [1:0]          err_code
);

  localparam bit               TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e              state;
  logic [2:0]          idx;
  logic [CNT_W-1:0]    cnt;
  logic [7:0]          xor_acc;
  logic [7:0]          cksum;
  logic [W_WEIGHT-1:0] sh_weight;
  logic [W_LEAK-1:0]   sh_leak1;
  logic [W_LEAK-1:0]   sh_leak2;
  logic [W_THR-1:0]    sh_thr;
  logic [W_CYC-1:0]    sh_cyc1;
  logic [W_CYC-1:0]    sh_cyc2;

  assign rx_ready  = (state != CHECK);
  assign load_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= IDX_HEADER;
      cnt           <= '0;
      xor_acc       <= '0;
      cksum         <= '0;
      sh_weight     <= '0;
      sh_leak1      <= '0;
      sh_leak2      <= '0;
      sh_thr        <= '0;
      sh_cyc1       <= '0;
      sh_cyc2       <= '0;
      weight_a      <= '0;
      leak_rate_1   <= '0;
      leak_rate_2   <= '0;
      threshold_min <= '0;
      leak_cycles_1 <= '0;
      leak_cycles_2 <= '0;
      params_ready  <= 1'b0;
      load_err      <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      // Clear first so an error raised in the same cycle overrides it.
      if (err_clear) begin
        load_err <= 1'b0;
        err_code <= ERR_NONE;
      end
      case (state)
        IDLE: begin
          if (rx_valid && rx_data == HEADER) begin
            state   <= RECV;
            idx     <= IDX_WEIGHT;
            xor_acc <= '0;
            cnt     <= '0;
          end
        end
        RECV: begin
          if (rx_valid) begin
            cnt <= '0;
            if (idx == IDX_CKSUM) begin
              cksum <= rx_data;
              state <= CHECK;
            end else begin
              xor_acc <= xor_acc ^ rx_data;
              idx     <= idx + 3'd1;
              case (idx)
                IDX_WEIGHT: sh_weight <= rx_data[W_WEIGHT-1:0];
                IDX_LEAK1:  sh_leak1  <= rx_data;
                IDX_LEAK2:  sh_leak2  <= rx_data;
                IDX_THR:    sh_thr    <= rx_data;
                IDX_CYC:    {sh_cyc2, sh_cyc1} <= rx_data;
                default:    ;
              endcase
            end
          end else if (TO_EN) begin
            if (cnt == TO_LAST) begin
              state    <= IDLE;
              idx      <= IDX_HEADER;
              cnt      <= '0;
              load_err <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          state <= IDLE;
          idx   <= IDX_HEADER;
          if (cksum != xor_acc) begin
            load_err <= 1'b1;
            err_code <= ERR_CKSUM;
          end else if (sh_thr == '0 || sh_thr[W_THR-1]) begin
            // threshold_max = 2*min must still fit in 8 bits
            load_err <= 1'b1;
            err_code <= ERR_RANGE;
          end else begin
            weight_a      <= sh_weight;
            leak_rate_1   <= sh_leak1;
            leak_rate_2   <= sh_leak2;
            threshold_min <= sh_thr;
            leak_cycles_1 <= sh_cyc1;
            leak_cycles_2 <= sh_cyc2;
            params_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= IDX_HEADER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_param_loader.sv
// Bench for neuron_param_loader: directed packets with literal expectations, then
// randomized frames/garbage/gaps checked every cycle against a frame-level model.
module tb_neuron_param_loader;

  localparam int         T   = 4;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       err_clear = 1'b0;
  logic       rx_ready;
  logic [2:0] weight_a;
  logic [7:0] leak_rate_1, leak_rate_2, threshold_min;
  logic [3:0] leak_cycles_1, leak_cycles_2;
  logic       params_ready, load_busy, load_err;
  logic [1:0] err_code;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 0;

  neuron_param_loader #(.HEADER(HDR), .TIMEOUT_CYC(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .err_clear(err_clear), .weight_a(weight_a),
    .leak_rate_1(leak_rate_1), .leak_rate_2(leak_rate_2),
    .threshold_min(threshold_min), .leak_cycles_1(leak_cycles_1),
    .leak_cycles_2(leak_cycles_2), .params_ready(params_ready),
    .load_busy(load_busy), .load_err(load_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame buffer filled byte by byte; a complete frame is judged one cycle later.
  logic [7:0] fr [0:6];
  int         m_len, m_idle;
  bit         m_judge;
  logic [7:0] m_par [0:5];
  bit         m_pr, m_err;
  logic [1:0] m_code;

  task automatic m_reset();
    m_len = 0; m_idle = 0; m_judge = 0;
    for (int i = 0; i < 6; i++) m_par[i] = 8'h00;
    m_pr = 0; m_err = 0; m_code = 2'b00;
  endtask

  initial begin
    bit         new_err;
    logic [1:0] nc;
    logic [7:0] x;
    m_reset();
    forever begin
      @(posedge clk);
      new_err = 0;
      nc = 2'b00;
      if (reset) m_reset();
      else begin
        if (err_clear) begin m_err = 0; m_code = 2'b00; end
        if (m_judge) begin
          x = fr[1] ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5];
          if (x != fr[6]) begin new_err = 1; nc = 2'b01; end
          else if (fr[4] == 0 || fr[4] > 127) begin new_err = 1; nc = 2'b10; end
          else begin
            m_par[0] = {5'b0, fr[1][2:0]};
            m_par[1] = fr[2];
            m_par[2] = fr[3];
            m_par[3] = fr[4];
            m_par[4] = {4'b0, fr[5][3:0]};
            m_par[5] = {4'b0, fr[5][7:4]};
            m_pr = 1;
          end
          m_judge = 0;
          m_len = 0;
        end else if (m_len == 0) begin
          if (rx_valid && rx_data == HDR) begin m_len = 1; m_idle = 0; end
        end else if (rx_valid) begin
          fr[m_len] = rx_data;
          m_len++;
          m_idle = 0;
          if (m_len == 7) m_judge = 1;
        end else begin
          m_idle++;
          if (m_idle == T) begin m_len = 0; new_err = 1; nc = 2'b11; end
        end
        if (new_err) begin m_err = 1; m_code = nc; end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rx_ready", {7'b0, rx_ready}, {7'b0, !m_judge});
      chk("load_busy", {7'b0, load_busy}, {7'b0, (m_len > 0) || m_judge});
      chk("weight_a", {5'b0, weight_a}, m_par[0]);
      chk("leak_rate_1", leak_rate_1, m_par[1]);
      chk("leak_rate_2", leak_rate_2, m_par[2]);
      chk("threshold_min", threshold_min, m_par[3]);
      chk("leak_cycles_1", {4'b0, leak_cycles_1}, m_par[4]);
      chk("leak_cycles_2", {4'b0, leak_cycles_2}, m_par[5]);
      chk("params_ready", {7'b0, params_ready}, {7'b0, m_pr});
      chk("load_err", {7'b0, load_err}, {7'b0, m_err});
      chk("err_code", {6'b0, err_code}, {6'b0, m_code});
    end
  end

  task automatic step(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b1, b2, b3, b4, b5, b6);
    step(1, HDR); step(1, b1); step(1, b2); step(1, b3); step(1, b4); step(1, b5); step(1, b6);
    step(0, 8'h00);
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    step(0, 8'h00);
    err_clear = 1'b0;
  endtask

  int q[$];

  task automatic push_byte(input logic [7:0] b);
    q.push_back(int'(b));
    if ($urandom_range(0, 9) == 0)
      repeat ($urandom_range(1, 5)) q.push_back(-1);
  endtask

  task automatic gen_item();
    logic [7:0] b [1:6];
    int kind;
    kind = $urandom_range(0, 5);
    if (kind == 5) begin
      repeat ($urandom_range(1, 4)) push_byte(8'($urandom_range(0, 255)));
      return;
    end
    for (int i = 1; i <= 5; i++) b[i] = 8'($urandom_range(0, 255));
    b[4] = 8'($urandom_range(1, 127));
    if (kind == 4) b[4] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(128, 255));
    b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    if (kind == 3) b[6] = b[6] ^ 8'(1 << $urandom_range(0, 7));
    push_byte(HDR);
    for (int i = 1; i <= 6; i++) push_byte(b[i]);
  endtask

  initial begin
    int v;
    reset = 1'b1;
    step(0, 8'h00);
    step(0, 8'h00);
    cmp_en = 1;
    reset = 1'b0;
    chk("rst_params_ready", {7'b0, params_ready}, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("rst_err_code", {6'b0, err_code}, 8'h00);
    chk("rst_weight", {5'b0, weight_a}, 8'h00);

    // good packet, byte held valid through the judge cycle must be refused
    step(1, HDR); step(1, 8'h05); step(1, 8'h02); step(1, 8'h01); step(1, 8'h20); step(1, 8'h23);
    rx_valid = 1'b1; rx_data = 8'h05;
    @(posedge clk); #1;
    rx_data = HDR;
    chk("pre_commit_pr", {7'b0, params_ready}, 8'h00);
    chk("check_rx_ready", {7'b0, rx_ready}, 8'h00);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("good_weight", {5'b0, weight_a}, 8'h05);
    chk("good_lr1", leak_rate_1, 8'h02);
    chk("good_lr2", leak_rate_2, 8'h01);
    chk("good_thr", threshold_min, 8'h20);
    chk("good_cyc1", {4'b0, leak_cycles_1}, 8'h03);
    chk("good_cyc2", {4'b0, leak_cycles_2}, 8'h02);
    chk("good_pr", {7'b0, params_ready}, 8'h01);
    chk("good_err", {7'b0, load_err}, 8'h00);
    chk("held_byte_busy", {7'b0, load_busy}, 8'h00);

    send_pkt(8'h05, 8'h02, 8'h01, 8'h20, 8'h23, 8'h06);
    chk("cksum_code", {6'b0, err_code}, 8'h01);
    chk("cksum_weight", {5'b0, weight_a}, 8'h05);
    clear_err();
    chk("clear_err", {7'b0, load_err}, 8'h00);

    send_pkt(8'h05, 8'h02, 8'h01, 8'h80, 8'h23, 8'hA5);
    chk("range80_code", {6'b0, err_code}, 8'h02);
    chk("range80_thr", threshold_min, 8'h20);
    clear_err();
    send_pkt(8'h05, 8'h02, 8'h01, 8'h00, 8'h23, 8'h25);
    chk("range00_code", {6'b0, err_code}, 8'h02);

    step(1, 8'h00); step(1, 8'hFF); step(1, 8'h13);
    send_pkt(8'h03, 8'h10, 8'h20, 8'h40, 8'h5A, 8'h29);
    chk("resync_weight", {5'b0, weight_a}, 8'h03);
    chk("resync_thr", threshold_min, 8'h40);
    chk("resync_cyc1", {4'b0, leak_cycles_1}, 8'h0A);
    chk("resync_cyc2", {4'b0, leak_cycles_2}, 8'h05);
    chk("commit_keeps_err", {7'b0, load_err}, 8'h01);

    clear_err();
    step(1, HDR); step(1, 8'h02);
    repeat (3) step(0, 8'h00);
    chk("to_still_busy", {7'b0, load_busy}, 8'h01);
    step(0, 8'h00);
    chk("to_busy", {7'b0, load_busy}, 8'h00);
    chk("to_code", {6'b0, err_code}, 8'h03);
    send_pkt(8'h05, 8'h02, 8'h01, 8'h20, 8'h23, 8'h05);
    chk("after_to_weight", {5'b0, weight_a}, 8'h05);

    step(1, HDR); step(1, 8'h05); step(1, 8'h02);
    reset = 1'b1;
    step(0, 8'h00);
    reset = 1'b0;
    chk("midrst_pr", {7'b0, params_ready}, 8'h00);
    chk("midrst_thr", threshold_min, 8'h00);
    chk("midrst_busy", {7'b0, load_busy}, 8'h00);
    chk("midrst_err", {7'b0, load_err}, 8'h00);

    for (int c = 0; c < 4000; c++) begin
      if (q.size() == 0) gen_item();
      v = q.pop_front();
      err_clear = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 699) == 0);
      if (v < 0) step(0, 8'($urandom_range(0, 255)));
      else step(1, 8'(v));
    end
    err_clear = 1'b0;
    reset = 1'b0;
    step(0, 8'h00);
    step(0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
